// File: rtl/cla_pkg.sv
// cla_pkg: shared state encoding and nibble-count helpers for the serial CLA sequencer
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE = 4;
  function automatic int nib_count(input int width);
    return width / NIBBLE;
  endfunction
  function automatic int idx_width(input int width);
    return (width / NIBBLE > 1) ? $clog2(width / NIBBLE) : 1;
  endfunction
endpackage

// File: rtl/cla_serial_sequencer_if.sv
// cla_serial_sequencer_if: operand/result valid-ready bus between requester and sequencer
interface cla_serial_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice
module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c0_i,
  output logic [3:0] s_o,
  output logic       c1_o,
  output logic       c2_o,
  output logic       c3_o,
  output logic       c4_o
);
  logic [3:0] p, g;
  assign p = a_i ^ b_i;
  assign g = a_i & b_i;
  assign c1_o = g[0] | (p[0] & c0_i);
  assign c2_o = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
  assign c3_o = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
  assign c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0_i);
  assign s_o = p ^ {c3_o, c2_o, c1_o, c0_i};
endmodule

// File: rtl/cla_serial_sequencer.sv
// cla_serial_sequencer: WIDTH-bit add/subtract done a nibble per cycle on one shared CLA slice
module cla_serial_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  cla_serial_sequencer_if.slave bus
);
  localparam int N  = nib_count(WIDTH);
  localparam int IW = idx_width(WIDTH);
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [3:0]       s;
  logic             c1, c2, c3, c4, accept, last, mid_carry_unused;
  cla4_slice u_slice (
    .a_i (a_q[NIBBLE*idx_q +: NIBBLE]),
    .b_i (b_q[NIBBLE*idx_q +: NIBBLE]),
    .c0_i(carry_q),
    .s_o (s),
    .c1_o(c1),
    .c2_o(c2),
    .c3_o(c3),
    .c4_o(c4)
  );
  assign mid_carry_unused = c1 ^ c2;
  assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q == RUN;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = idx_q == IW'(N - 1);
  // Subtract is A + ~B + 1, so the carry-in is forced high and cin is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      state_d = RUN;
      idx_d   = '0;
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub | bus.cin;
    end else if (state_q == RUN) begin
      sum_d[NIBBLE*idx_q +: NIBBLE] = s;
      carry_d = c4;
      idx_d   = last ? '0 : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
      cout_d  = last ? c4 : cout_q;
      ovf_d   = last ? c3 ^ c4 : ovf_q;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_cla_serial_sequencer.sv
// tb_cla_serial_sequencer: directed vectors on WIDTH=16 plus exhaustive WIDTH=4 sweep
module tb_cla_serial_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cla_serial_sequencer_if #(.WIDTH(16)) b16 ();
  cla_serial_sequencer_if #(.WIDTH(4))  b4 ();
  cla_serial_sequencer #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  cla_serial_sequencer #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4.slave));
  int checks   = 0;
  int failures = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    b16.a        = a;
    b16.b        = b;
    b16.cin      = cin;
    b16.sub      = sub;
    b16.in_valid = 1'b1;
    chk("in_ready_before_accept16", 32'(b16.in_ready), 1);
    tick;
    b16.in_valid = 1'b0;
    b16.a        = 16'($urandom);
    b16.b        = 16'($urandom);
    b16.cin      = 1'($urandom);
    b16.sub      = 1'($urandom);
  endtask
  task automatic wait16(output int cyc);
    cyc = 0;
    while (b16.out_valid !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
  endtask
  task automatic wait4(output int cyc);
    cyc = 0;
    while (b4.out_valid !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
  endtask
  initial begin
    int cyc;
    logic seen;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
    b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0;
    b4.in_valid  = 1'b0; b4.out_ready  = 1'b0; b4.a  = '0; b4.b  = '0; b4.cin  = 1'b0; b4.sub  = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready",  32'(b16.in_ready), 1);
    chk("rst_out_valid", 32'(b16.out_valid), 0);
    chk("rst_busy",      32'(b16.busy), 0);
    chk("rst_result",    32'({b16.cout, b16.ovf, b16.sum}), 0);
    chk("rst_w4_ready",  32'({b4.in_ready, b4.out_valid, b4.busy}), 32'b100);
    // table-driven vectors, each released after checking
    for (int i = 0; i < 9; i++) begin
      issue16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk($sformatf("vec%0d_busy", i), 32'(b16.busy), 1);
      wait16(cyc);
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 4);
      chk($sformatf("vec%0d_sum", i), 32'(b16.sum), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout_ovf", i), 32'({b16.cout, b16.ovf}), 32'({vecs[i].co, vecs[i].ov}));
      b16.out_ready = 1'b1;
      tick;
      b16.out_ready = 1'b0;
      chk($sformatf("vec%0d_release", i), 32'({b16.out_valid, b16.in_ready, b16.busy}), 32'b010);
    end
    // reset one cycle into RUN discards the transaction
    issue16(16'h1234, 16'h4321, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_state", 32'({b16.out_valid, b16.in_ready, b16.busy}), 32'b010);
    chk("midrst_sum", 32'(b16.sum), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen = seen | b16.out_valid;
    end
    chk("midrst_no_result", 32'(seen), 0);
    // backpressure then back-to-back accept in the release edge
    issue16(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait16(cyc);
    chk("bp_latency", 32'(cyc), 4);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("bp_hold%0d", i), 32'({b16.out_valid, b16.in_ready, b16.sum}), 32'({2'b10, 16'h7FFF}));
    end
    b16.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(b16.in_ready), 1);
    issue16(16'h0001, 16'h0001, 1'b0, 1'b0);
    b16.out_ready = 1'b0;
    chk("b2b_busy", 32'({b16.busy, b16.out_valid}), 32'b10);
    wait16(cyc);
    chk("b2b_latency", 32'(cyc), 4);
    chk("b2b_result", 32'({b16.cout, b16.ovf, b16.sum}), 32'h0002);
    b16.out_ready = 1'b1;
    tick;
    b16.out_ready = 1'b0;
    // exhaustive WIDTH=4 against arithmetic reference
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int m = 0; m < 4; m++) begin
          logic [3:0] bb;
          logic [4:0] full;
          logic       c0, ov;
          bb   = m[1] ? ~4'(b) : 4'(b);
          c0   = m[1] | m[0];
          full = {1'b0, 4'(a)} + {1'b0, bb} + 5'(c0);
          ov   = (a[3] == bb[3]) && (full[3] != a[3]);
          b4.a = 4'(a); b4.b = 4'(b); b4.cin = m[0]; b4.sub = m[1];
          b4.in_valid = 1'b1;
          tick;
          b4.in_valid = 1'b0;
          b4.a = 4'($urandom); b4.b = 4'($urandom); b4.cin = 1'($urandom); b4.sub = 1'($urandom);
          wait4(cyc);
          chk($sformatf("w4_lat_a%0h_b%0h_m%0d", a, b, m), 32'(cyc), 1);
          chk($sformatf("w4_res_a%0h_b%0h_m%0d", a, b, m), 32'({b4.cout, b4.ovf, b4.sum}), 32'({full[4], ov, full[3:0]}));
          b4.out_ready = 1'b1;
          tick;
          b4.out_ready = 1'b0;
        end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
